// File: rtl/alu_r32i_pkg.sv
// alu_r32i_pkg: shared definitions for the RV32I-style ALU.
//   - alucode_e : 4-bit operation select encoding
//   - DATA_W    : default operand/result width
package alu_r32i_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SSL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SSR  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_CPY  = 4'd10
  } alucode_e;

endpackage

// File: rtl/alu_r32i_core.sv
// alu_r32i_core: purely combinational ALU datapath.
//   A, B     : raw operand bits (signedness chosen per operation)
//   alucode  : operation select (alucode_e encoding)
//   w_result : next result value; unused codes yield 0
module alu_r32i_core
  import alu_r32i_pkg::*;
#(
  parameter int dataW = DATA_W
) (
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [3:0]       alucode,
  output logic [dataW-1:0] w_result
);

  localparam int SHW = $clog2(dataW);

  // Only the low bits of B select the shift distance; upper bits are ignored.
  logic [SHW-1:0] w_shamt;
  assign w_shamt = B[SHW-1:0];

  always_comb begin
    w_result = '0;
    case (alucode)
      ALU_ADD:  w_result = A + B;
      ALU_SUB:  w_result = A - B;
      ALU_SSL:  w_result = A << w_shamt;
      ALU_SLT:  w_result = {{(dataW-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: w_result = {{(dataW-1){1'b0}}, (A < B)};
      ALU_XOR:  w_result = A ^ B;
      ALU_SSR:  w_result = A >> w_shamt;
      ALU_SRA:  w_result = $unsigned($signed(A) >>> w_shamt);
      ALU_OR:   w_result = A | B;
      ALU_AND:  w_result = A & B;
      ALU_CPY:  w_result = B;
      default:  w_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_r32i.sv
// alu_r32i: registered ALU, one-cycle latency, one result per cycle.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   in_valid  : A/B/alucode sampled on this edge
//   A, B      : operands; alucode selects the operation
//   result    : registered result, held while in_valid is low
//   out_valid : in_valid delayed one cycle
//   zero      : registered, high when result is 0
module alu_r32i
  import alu_r32i_pkg::*;
#(
  parameter int dataW = DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [3:0]       alucode,
  output logic [dataW-1:0] result,
  output logic             out_valid,
  output logic             zero
);

  logic [dataW-1:0] w_next;
  logic [dataW-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;

  alu_r32i_core #(.dataW(dataW)) u_core (
    .A        (A),
    .B        (B),
    .alucode  (alucode),
    .w_result (w_next)
  );

  // zero is derived from the same value being loaded so the pair never skews.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_next;
        r_zero   <= (w_next == '0);
      end
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_r32i.sv
module tb_alu_r32i;
  import alu_r32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alucode;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_r32i #(.dataW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .alucode   (alucode),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample #1 after the edge.
  task automatic drive(input logic rst, input logic vld, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    reset = rst; in_valid = vld; alucode = code; A = a; B = b;
    @(posedge clock);
    #1;
  endtask

  // Valid op: checks result, zero and out_valid right after the sampling edge.
  task automatic op(input string tag, input logic [3:0] code,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_res, input logic exp_zero);
    drive(1'b0, 1'b1, code, a, b);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alucode = 4'd0; A = '0; B = '0;

    // Reset with an operation presented: must be discarded.
    drive(1'b1, 1'b1, ALU_ADD, 32'd9, 32'd4);
    drive(1'b1, 1'b1, ALU_ADD, 32'd9, 32'd4);
    chk("rst.res", result, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd1);
    chk("rst.ov", {31'd0, out_valid}, 32'd0);

    // First edge after reset is accepted; back-to-back valid below.
    op("add",      ALU_ADD,  32'd9,        32'd4, 32'd13,        1'b0);
    op("sub",      ALU_SUB,  32'd9,        32'd4, 32'd5,         1'b0);
    op("slt0",     ALU_SLT,  32'd9,        32'd4, 32'd0,         1'b1);
    op("slt1",     ALU_SLT,  32'd2,        32'd4, 32'd1,         1'b0);
    op("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'd4, 32'd0,         1'b1);
    op("sltneg",   ALU_SLT,  32'hFFFFFFFF, 32'd4, 32'd1,         1'b0);
    op("and",      ALU_AND,  32'd9,        32'd4, 32'd0,         1'b1);
    op("or",       ALU_OR,   32'd9,        32'd4, 32'd13,        1'b0);
    op("xor",      ALU_XOR,  32'd9,        32'd4, 32'd13,        1'b0);
    op("ssl1",     ALU_SSL,  32'd9,        32'd1, 32'd18,        1'b0);
    op("ssl3",     ALU_SSL,  32'd9,        32'd3, 32'd72,        1'b0);
    op("ssr3",     ALU_SSR,  32'd9,        32'd3, 32'd1,         1'b0);
    op("sra3",     ALU_SRA,  32'd9,        32'd3, 32'd1,         1'b0);
    op("sraneg",   ALU_SRA,  32'hFFFFFFF7, 32'd3, 32'hFFFFFFFE,  1'b0);
    op("ssrneg",   ALU_SSR,  32'hFFFFFFF7, 32'd3, 32'h1FFFFFFE,  1'b0);
    op("ssl35",    ALU_SSL,  32'd9,        32'd35, 32'd72,       1'b0);
    op("sra0",     ALU_SRA,  32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7,  1'b0);
    op("ssr0",     ALU_SSR,  32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7,  1'b0);
    op("ssl0",     ALU_SSL,  32'h80000001, 32'd0, 32'h80000001,  1'b0);
    op("sslmsb",   ALU_SSL,  32'h80000001, 32'd31, 32'h80000000, 1'b0);
    op("addwrap",  ALU_ADD,  32'hFFFFFFFF, 32'd1, 32'd0,         1'b1);
    op("subwrap",  ALU_SUB,  32'd0,        32'd1, 32'hFFFFFFFF,  1'b0);
    op("sltmin",   ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'd1,  1'b0);
    op("sltumin",  ALU_SLTU, 32'h80000000, 32'h7FFFFFFF, 32'd0,  1'b1);
    op("cpy",      ALU_CPY,  32'hFFFFFFF7, 32'd3, 32'd3,         1'b0);
    op("code12",   4'd12,    32'd9,        32'd4, 32'd0,         1'b1);
    op("code15",   4'd15,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  1'b1);
    op("cpybig",   ALU_CPY,  32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Idle for two cycles: result/zero held, out_valid low.
    drive(1'b0, 1'b0, ALU_ADD, 32'd1, 32'd1);
    chk("hold1.res", result, 32'hDEADBEEF);
    chk("hold1.zero", {31'd0, zero}, 32'd0);
    chk("hold1.ov", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 1'b0, ALU_SUB, 32'd5, 32'd5);
    chk("hold2.res", result, 32'hDEADBEEF);
    chk("hold2.ov", {31'd0, out_valid}, 32'd0);

    // Resume, then reset with in_valid high.
    op("resume", ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    drive(1'b1, 1'b1, ALU_ADD, 32'd9, 32'd4);
    chk("rst2.res", result, 32'd0);
    chk("rst2.zero", {31'd0, zero}, 32'd1);
    chk("rst2.ov", {31'd0, out_valid}, 32'd0);

    // Released with in_valid low: nothing emitted for the discarded op.
    drive(1'b0, 1'b0, ALU_ADD, 32'd9, 32'd4);
    chk("postrst.res", result, 32'd0);
    chk("postrst.ov", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
